// File: rtl/fixed_serializer_pkg.sv
// Shared types and helpers for the fixed-point vector serializer.
package fixed_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Upper bounds for the element-select helper; vectors and elements must fit.
  localparam int MAX_VEC_W  = 1024;
  localparam int MAX_ELEM_W = 64;

  // Element idx of a packed vector whose elements are elem_w bits wide.
  function automatic logic [MAX_ELEM_W-1:0] vec_elem(
    input logic [MAX_VEC_W-1:0] vec,
    input int                   idx,
    input int                   elem_w
  );
    return MAX_ELEM_W'(vec >> (idx * elem_w));
  endfunction

endpackage

// File: rtl/fixed_vector_skid.sv
// One-entry valid/ready register slice with bypass; s_ready comes straight from a flop.
module fixed_vector_skid #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             full_q, full_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             s_fire;

  assign s_fire  = s_valid && ready_q;
  assign s_ready = ready_q;
  // Empty slice passes the incoming vector straight through, keeping load latency at one edge.
  assign m_valid = full_q || s_fire;
  assign m_data  = full_q ? hold_q : s_data;

  always_comb begin
    full_d = full_q;
    hold_d = hold_q;
    if (full_q) begin
      if (m_ready) full_d = 1'b0;
    end else if (s_fire && !m_ready) begin
      full_d = 1'b1;
      hold_d = s_data;
    end
    ready_d = !full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/fixed_serializer.sv
// Vector-to-scalar serializer: one packed vector in, OUT_DEPTH elements out, element 0 first.
// Optional input skid slice enabled by defining FIXED_SERIALIZER_SKID_EN.
module fixed_serializer
  import fixed_serializer_pkg::*;
#(
  parameter int OUT_DEPTH     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int COUNTER_WIDTH = $clog2(OUT_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OUT_DEPTH*DATA_WIDTH-1:0] data_in,
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready,
  output logic                            data_out_last,
  output logic [COUNTER_WIDTH-1:0]        counter
);

  localparam int VEC_W = OUT_DEPTH * DATA_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(OUT_DEPTH - 1);

  logic [VEC_W-1:0] vec_data;
  logic             vec_valid;
  logic             vec_ready;

`ifdef FIXED_SERIALIZER_SKID_EN
  fixed_vector_skid #(
    .WIDTH(VEC_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .s_data (data_in),
    .s_valid(data_in_valid),
    .s_ready(data_in_ready),
    .m_data (vec_data),
    .m_valid(vec_valid),
    .m_ready(vec_ready)
  );
`else
  assign vec_data      = data_in;
  assign vec_valid     = data_in_valid;
  assign data_in_ready = vec_ready;
`endif

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [VEC_W-1:0]         data_q, data_d;
  logic                     is_last;
  logic                     out_fire;
  logic                     load;

  assign is_last        = (counter_q == LAST_IDX);
  assign data_out_valid = (state_q == EMIT);
  assign data_out_last  = data_out_valid && is_last;
  assign counter        = counter_q;
  assign data_out       = DATA_WIDTH'(vec_elem(MAX_VEC_W'(data_q), int'(counter_q), DATA_WIDTH));

  // Working register frees up on the last-beat handshake, so a new vector can load that same edge.
  assign vec_ready = (state_q == IDLE) || (data_out_last && data_out_ready);
  assign out_fire  = data_out_valid && data_out_ready;
  assign load      = vec_valid && vec_ready;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    data_d    = data_q;
    if (out_fire) begin
      if (is_last) begin
        counter_d = '0;
        state_d   = IDLE;
      end else begin
        counter_d = counter_q + COUNTER_WIDTH'(1);
      end
    end
    if (load) begin
      data_d    = vec_data;
      counter_d = '0;
      state_d   = EMIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_fixed_serializer.sv
// Directed self-checking bench: OUT_DEPTH=4/DATA_WIDTH=8 instance plus an OUT_DEPTH=1 instance.
module tb_fixed_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] a_in_data  = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [7:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic        a_out_last;
  logic [2:0]  a_counter;

  logic [7:0]  b_in_data  = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic        b_out_last;
  logic [0:0]  b_counter;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fixed_serializer #(.OUT_DEPTH(4), .DATA_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst),
    .data_in(a_in_data), .data_in_valid(a_in_valid), .data_in_ready(a_in_ready),
    .data_out(a_out_data), .data_out_valid(a_out_valid), .data_out_ready(a_out_ready),
    .data_out_last(a_out_last), .counter(a_counter)
  );

  fixed_serializer #(.OUT_DEPTH(1), .DATA_WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .data_in(b_in_data), .data_in_valid(b_in_valid), .data_in_ready(b_in_ready),
    .data_out(b_out_data), .data_out_valid(b_out_valid), .data_out_ready(b_out_ready),
    .data_out_last(b_out_last), .counter(b_counter)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", a_out_valid); end
    total++;
    if (a_out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", a_out_last); end
    total++;
    if (a_counter !== 3'd0) begin bad++; $display("FAIL reset_counter got=%0d want=0", a_counter); end
    total++;
    if (a_out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", a_out_data); end
`ifdef FIXED_SERIALIZER_SKID_EN
    total++;
    if (a_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", a_in_ready); end
`else
    total++;
    if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
`endif
    rst = 1'b0;
    step();
    total++;
    if (a_in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", a_in_ready); end
    $display("reset: checked idle outputs");
  endtask

  // Sends one vector on the depth-4 instance and checks four unstalled beats.
  task automatic send_and_check(input string name, input logic [31:0] vec, input logic [7:0] exp [4]);
    a_out_ready = 1'b1;
    a_in_data   = vec;
    a_in_valid  = 1'b1;
    total++;
    if (a_in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%b want=1", name, a_in_ready); end
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp[i] || a_counter !== 3'(i) || a_out_last !== (i == 3)) begin
        bad++;
        $display("FAIL %s_beat%0d got v=%b d=%h c=%0d l=%b want v=1 d=%h c=%0d l=%b",
                 name, i, a_out_valid, a_out_data, a_counter, a_out_last, exp[i], i, (i == 3));
      end
      step();
    end
    total++;
    if (a_out_valid !== 1'b0) begin bad++; $display("FAIL %s_idle got=%b want=0", name, a_out_valid); end
    $display("%s: vector %h sent", name, vec);
  endtask

  task automatic test_basic();
    logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_and_check("basic", 32'h04030201, exp);
  endtask

  task automatic test_signed();
    logic [7:0] exp [4] = '{8'hFF, 8'h00, 8'h7F, 8'h80};
    send_and_check("signed", 32'h807F00FF, exp);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24};
    logic       fire;
    a_out_ready = 1'b1;
    a_in_data   = 32'h14131211;
    a_in_valid  = 1'b1;
    step();
    a_in_data = 32'h24232221;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp[i] || a_counter !== 3'(i % 4) || a_out_last !== (i % 4 == 3)) begin
        bad++;
        $display("FAIL b2b_beat%0d got v=%b d=%h c=%0d l=%b want v=1 d=%h c=%0d l=%b",
                 i, a_out_valid, a_out_data, a_counter, a_out_last, exp[i], i % 4, (i % 4 == 3));
      end
`ifndef FIXED_SERIALIZER_SKID_EN
      if (i < 4) begin
        total++;
        if (a_in_ready !== (i == 3)) begin bad++; $display("FAIL b2b_in_ready%0d got=%b want=%b", i, a_in_ready, (i == 3)); end
      end
`endif
      fire = a_in_valid && a_in_ready;
      step();
      if (fire) a_in_valid = 1'b0;
    end
    total++;
    if (a_out_valid !== 1'b0 || a_in_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end got v=%b pending=%b want 0 0", a_out_valid, a_in_valid);
    end
    $display("back_to_back: 8 beats checked");
  endtask

  task automatic test_backpressure();
    logic pat [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int   k = 0;
    int   cyc = 0;
    a_in_data  = 32'h34333231;
    a_in_valid = 1'b1;
    a_out_ready = 1'b0;
    step();
    a_in_valid = 1'b0;
    while (k < 4 && cyc < 12) begin
      a_out_ready = pat[cyc];
      #1;
      total++;
      if (a_out_valid !== 1'b1 || a_out_data !== 8'(8'h31 + k) || a_counter !== 3'(k) || a_out_last !== (k == 3)) begin
        bad++;
        $display("FAIL bp_cyc%0d got v=%b d=%h c=%0d l=%b want v=1 d=%h c=%0d l=%b",
                 cyc, a_out_valid, a_out_data, a_counter, a_out_last, 8'(8'h31 + k), k, (k == 3));
      end
      step();
      if (pat[cyc]) k++;
      cyc++;
    end
    total++;
    if (k != 4 || a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_done got beats=%0d v=%b want 4 0", k, a_out_valid); end
    a_out_ready = 1'b1;
    $display("backpressure: %0d cycles", cyc);
  endtask

  task automatic test_reset_mid();
    int wait_cyc = 0;
    a_out_ready = 1'b1;
    a_in_data   = 32'h44434241;
    a_in_valid  = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    total++;
    if (a_out_data !== 8'h43 || a_counter !== 3'd2) begin
      bad++; $display("FAIL rstmid_pre got d=%h c=%0d want 43 2", a_out_data, a_counter);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_counter !== 3'd0 || a_out_last !== 1'b0 || a_out_data !== 8'h00) begin
      bad++; $display("FAIL rstmid_async got v=%b c=%0d l=%b d=%h want 0 0 0 00", a_out_valid, a_counter, a_out_last, a_out_data);
    end
    #1 rst = 1'b0;
    step();
    while (a_in_ready !== 1'b1 && wait_cyc < 5) begin step(); wait_cyc++; end
    total++;
    if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready_timeout got=%b want=1", a_in_ready); end
    a_in_data  = 32'h54535251;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    total++;
    if (a_out_valid !== 1'b1 || a_out_data !== 8'h51 || a_counter !== 3'd0) begin
      bad++; $display("FAIL rstmid_restart got v=%b d=%h c=%0d want 1 51 0", a_out_valid, a_out_data, a_counter);
    end
    for (int i = 0; i < 4; i++) step();
    $display("reset_mid: restart from element 0");
  endtask

  task automatic test_depth1();
    logic [7:0] vals [3] = '{8'h05, 8'h06, 8'h07};
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    int held;
    logic in_fire, out_fire, exp_ready;
    while (recv < 3 && cyc < 30) begin
      b_out_ready = (cyc >= 3);
      b_in_valid  = (sent < 3);
      b_in_data   = (sent < 3) ? vals[sent] : 8'h00;
      #1;
      held = sent - recv;
`ifdef FIXED_SERIALIZER_SKID_EN
      exp_ready = (held < 2);
`else
      exp_ready = (held == 0) || b_out_ready;
`endif
      total++;
      if (b_in_ready !== exp_ready) begin bad++; $display("FAIL d1_in_ready cyc%0d got=%b want=%b", cyc, b_in_ready, exp_ready); end
      total++;
      if (b_out_valid !== (held > 0)) begin bad++; $display("FAIL d1_valid cyc%0d got=%b want=%b", cyc, b_out_valid, (held > 0)); end
      if (held > 0) begin
        total++;
        if (b_out_data !== vals[recv] || b_out_last !== 1'b1 || b_counter !== 1'b0) begin
          bad++; $display("FAIL d1_beat cyc%0d got d=%h l=%b c=%0d want %h 1 0", cyc, b_out_data, b_out_last, b_counter, vals[recv]);
        end
      end
      in_fire  = b_in_valid && b_in_ready;
      out_fire = b_out_valid && b_out_ready;
      step();
      if (in_fire) sent++;
      if (out_fire) recv++;
      cyc++;
    end
    total++;
    if (recv != 3) begin bad++; $display("FAIL d1_timeout got beats=%0d want 3", recv); end
    b_in_valid = 1'b0;
    $display("depth1: %0d beats in %0d cycles", recv, cyc);
  endtask

  initial begin
    #12;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_signed();
    test_reset_mid();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
